// File: rtl/mctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, FSM states,
// instruction class indices and the datapath mux select values.
package mctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BMEM = 6'b010100;
    localparam logic [5:0] OP_JS   = 6'b010011;
    localparam logic [5:0] OP_JZ   = 6'b011010;

    localparam logic [5:0] FN_PCTOREG = 6'b010110;
    localparam logic [5:0] FN_JMEM    = 6'b101101;

    typedef enum logic [2:0] {S_RST, S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

    // Bit positions in the one-hot class vector
    localparam int NCLS       = 9;
    localparam int CL_R       = 0;
    localparam int CL_PCTOREG = 1;
    localparam int CL_JMEM    = 2;
    localparam int CL_LW      = 3;
    localparam int CL_SW      = 4;
    localparam int CL_BEQ     = 5;
    localparam int CL_BMEM    = 6;
    localparam int CL_JS      = 7;
    localparam int CL_JZ      = 8;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_MDR    = 2'd3;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] SRCB_RT    = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_SHIMM = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode/funct classifier producing a one-hot class vector;
// anything that matches no class is flagged illegal.
module op_class_decode
    import mctrl_pkg::*;
(
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    output logic [NCLS-1:0] cls,
    output logic            illegal
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_R: begin
                if (funct == FN_PCTOREG)
                    cls[CL_PCTOREG] = 1'b1;
                else if (funct == FN_JMEM)
                    cls[CL_JMEM] = 1'b1;
                else
                    cls[CL_R] = 1'b1;
            end
            OP_LW:   cls[CL_LW]   = 1'b1;
            OP_SW:   cls[CL_SW]   = 1'b1;
            OP_BEQ:  cls[CL_BEQ]  = 1'b1;
            OP_BMEM: cls[CL_BMEM] = 1'b1;
            OP_JS:   cls[CL_JS]   = 1'b1;
            OP_JZ:   cls[CL_JZ]   = 1'b1;
            default: cls = '0;
        endcase
        illegal = ~|cls;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: steps each instruction through IF/ID/EX/MEM/WB over a
// shared req/ack memory port, with an optional memory-wait timeout.
module multicycle_ctrl
    import mctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       z_flag,
    output logic       illegal,
    output logic       mem_err
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t          state, next_state;
    logic [NCLS-1:0] cls;
    logic            dec_illegal;
    logic            zero_ex;
    logic [CW-1:0]   wait_cnt;
    logic            mem_phase, timeout, ack;

    op_class_decode u_dec (
        .opcode  (opcode),
        .funct   (funct),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    // A timeout cycle drops the request, so an ack arriving in it is ignored
    assign mem_phase = (state == S_IF) || (state == S_MEM);
    assign timeout   = (MEM_TIMEOUT != 0) && mem_phase && (wait_cnt == CW'(MEM_TIMEOUT));
    assign ack       = mem_phase && mem_ack && !timeout;

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        wb_sel     = WB_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        case (state)
            S_RST: next_state = S_IF;
            S_IF: begin
                mem_req   = !timeout;
                alu_src_b = SRCB_FOUR;
                if (timeout) begin
                    mem_err    = 1'b1;
                    next_state = S_IF;
                end else if (ack) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = PC_ALU;
                    next_state = S_ID;
                end
            end
            S_ID: begin
                alu_src_b = SRCB_SHIMM;
                if (dec_illegal) begin
                    illegal    = 1'b1;
                    next_state = S_IF;
                end else if (cls[CL_JZ]) begin
                    pc_write   = z_flag;
                    pc_src     = PC_JUMP;
                    next_state = S_IF;
                end else begin
                    next_state = S_EX;
                end
            end
            S_EX: begin
                if (cls[CL_R]) begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_FUNCT;
                    next_state = S_WB;
                end else if (cls[CL_LW] || cls[CL_SW] || cls[CL_BMEM]) begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    next_state = S_MEM;
                end else if (cls[CL_JMEM]) begin
                    alu_src_a  = 1'b1;
                    next_state = S_MEM;
                end else if (cls[CL_BEQ]) begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_write   = alu_zero;
                    pc_src     = PC_ALUOUT;
                    next_state = S_IF;
                end else if (cls[CL_JS]) begin
                    next_state = S_MEM;
                end else if (cls[CL_PCTOREG]) begin
                    next_state = S_WB;
                end else begin
                    next_state = S_IF;
                end
            end
            S_MEM: begin
                mem_req = !timeout;
                mem_we  = !timeout && (cls[CL_SW] || cls[CL_JS]);
                iord    = 1'b1;
                if (timeout) begin
                    mem_err    = 1'b1;
                    next_state = S_IF;
                end else if (ack) begin
                    next_state = cls[CL_LW] ? S_WB : S_IF;
                    if (cls[CL_JS]) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end else if (cls[CL_JMEM]) begin
                        pc_write = 1'b1;
                        pc_src   = PC_MDR;
                    end else if (cls[CL_BMEM]) begin
                        pc_write = z_flag;
                        pc_src   = PC_MDR;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                if (cls[CL_LW]) begin
                    wb_sel = WB_MDR;
                end else if (cls[CL_PCTOREG]) begin
                    reg_dst = 1'b1;
                    wb_sel  = WB_PC;
                end else begin
                    reg_dst = 1'b1;
                end
                next_state = S_IF;
            end
            default: next_state = S_RST;
        endcase
    end

    // z_flag takes the ALU zero seen in EX, committed only when an R op retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RST;
            wait_cnt <= '0;
            zero_ex  <= 1'b0;
            z_flag   <= 1'b0;
        end else begin
            state <= next_state;
            if ((MEM_TIMEOUT != 0) && mem_phase && !ack && !timeout)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (state == S_EX)
                zero_ex <= alu_zero;
            if (state == S_WB && cls[CL_R])
                z_flag <= zero_ex;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-instruction cycle counts and control-event totals
// compared against a class-level reference model under random memory waits.
module tb_multicycle_ctrl;

    typedef enum int {K_R, K_PCTOREG, K_JMEM, K_LW, K_SW, K_BEQ, K_BMEM, K_JS, K_JZ, K_ILL} kind_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst;
    logic       alu_src_a, z_flag, illegal, mem_err;
    logic [1:0] pc_src, wb_sel, alu_src_b, alu_op;

    int  tests = 0;
    int  fails = 0;
    logic zm = 1'b0;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct     (funct),
        .alu_zero  (alu_zero),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .wb_sel    (wb_sel),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .z_flag    (z_flag),
        .illegal   (illegal),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] random_illegal_op();
        logic [5:0] op;
        do op = 6'($urandom_range(63));
        while (op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h14, 6'h13, 6'h1a});
        return op;
    endfunction

    // Runs one instruction for exactly the model's CPI and tallies what the controller did
    task automatic apply_stimulus(input kind_t k, input int if_wait, input int mem_wait,
                                  input logic az, input logic [5:0] ill_op);
        int   base, cycles, phase, reqcnt, target;
        int   irw, pcw, first_src, last_src, rgw, rgsel, mreq, mwe, miord, ill, merr;
        int   exp_pcw, exp_last, exp_rgw, exp_rgsel, exp_mem;
        logic has_mem, next_z;
        logic [5:0] op, fn;
        string nm;

        nm      = k.name();
        has_mem = k inside {K_LW, K_SW, K_BMEM, K_JS, K_JMEM};
        case (k)
            K_LW:          base = 5;
            K_BEQ:         base = 3;
            K_JZ, K_ILL:   base = 2;
            default:       base = 4;
        endcase
        cycles  = base + if_wait + (has_mem ? mem_wait : 0);
        exp_mem = has_mem ? mem_wait + 1 : 0;
        exp_pcw = 1;
        exp_last = 0;
        case (k)
            K_BEQ:  if (az) begin exp_pcw = 2; exp_last = 1; end
            K_JZ:   if (zm) begin exp_pcw = 2; exp_last = 2; end
            K_BMEM: if (zm) begin exp_pcw = 2; exp_last = 3; end
            K_JMEM: begin exp_pcw = 2; exp_last = 3; end
            K_JS:   begin exp_pcw = 2; exp_last = 2; end
            default: ;
        endcase
        exp_rgw   = (k inside {K_R, K_LW, K_PCTOREG}) ? 1 : 0;
        exp_rgsel = (k == K_R) ? 3'b100 : (k == K_LW) ? 3'b001 : (k == K_PCTOREG) ? 3'b110 : 0;
        next_z    = (k == K_R) ? az : zm;

        fn = 6'($urandom_range(63));
        case (k)
            K_R: begin
                op = 6'h00;
                if (fn == 6'b010110 || fn == 6'b101101) fn = fn ^ 6'd1;
            end
            K_PCTOREG: begin op = 6'h00; fn = 6'b010110; end
            K_JMEM:    begin op = 6'h00; fn = 6'b101101; end
            K_LW:      op = 6'b100011;
            K_SW:      op = 6'b101011;
            K_BEQ:     op = 6'b000100;
            K_BMEM:    op = 6'b010100;
            K_JS:      op = 6'b010011;
            K_JZ:      op = 6'b011010;
            default:   op = ill_op;
        endcase

        {phase, reqcnt, irw, pcw, first_src, last_src, rgw, rgsel, mreq, mwe, miord, ill, merr} = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (c == 0) begin
                opcode   = op;
                funct    = fn;
                alu_zero = az;
                check_output({nm, " start_in_if"}, {mem_req, iord}, 2'b10);
                check_output({nm, " z_flag_prior"}, z_flag, zm);
            end
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                reqcnt++;
                target = (phase == 0) ? if_wait : mem_wait;
                if (reqcnt == target + 1) begin
                    mem_ack = 1'b1;
                    reqcnt  = 0;
                    phase++;
                end
            end
            #1;
            mreq  += int'(mem_req);
            mwe   += int'(mem_req & mem_we);
            miord += int'(mem_req & iord);
            irw   += int'(ir_write);
            ill   += int'(illegal);
            merr  += int'(mem_err);
            if (pc_write === 1'b1) begin
                pcw++;
                if (pcw == 1) first_src = int'(pc_src);
                last_src = int'(pc_src);
            end
            if (reg_write === 1'b1) begin
                rgw++;
                rgsel = int'({reg_dst, wb_sel});
            end
        end

        check_output({nm, " ir_write_count"}, irw, 1);
        check_output({nm, " pc_write_count"}, pcw, exp_pcw);
        check_output({nm, " fetch_pc_src"}, first_src, 0);
        check_output({nm, " last_pc_src"}, last_src, exp_last);
        check_output({nm, " reg_write_count"}, rgw, exp_rgw);
        check_output({nm, " wb_select"}, rgsel, exp_rgsel);
        check_output({nm, " mem_req_cycles"}, mreq, (if_wait + 1) + exp_mem);
        check_output({nm, " mem_we_cycles"}, mwe, (k inside {K_SW, K_JS}) ? exp_mem : 0);
        check_output({nm, " iord_cycles"}, miord, exp_mem);
        check_output({nm, " illegal_count"}, ill, (k == K_ILL) ? 1 : 0);
        check_output({nm, " mem_err_count"}, merr, 0);
        zm = next_z;
    endtask

    initial begin
        // Reset: every output quiet, z_flag clear, still quiet before the first edge after release
        repeat (2) @(negedge clk);
        #1;
        check_output("reset_outputs", {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                     reg_dst, wb_sel, alu_src_a, alu_src_b, alu_op, illegal, mem_err}, 0);
        check_output("reset_z_flag", z_flag, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("rst_state_no_req", mem_req, 1'b0);

        apply_stimulus(K_R, 0, 0, 1'b1, 6'h3f);
        apply_stimulus(K_LW, 3, 3, 1'b0, 6'h3f);
        apply_stimulus(K_BEQ, 0, 0, 1'b1, 6'h3f);
        apply_stimulus(K_BEQ, 1, 0, 1'b0, 6'h3f);
        apply_stimulus(K_JZ, 0, 0, 1'b0, 6'h3f);
        apply_stimulus(K_R, 0, 0, 1'b0, 6'h3f);
        apply_stimulus(K_JZ, 2, 0, 1'b1, 6'h3f);
        apply_stimulus(K_JS, 0, 1, 1'b0, 6'h3f);
        apply_stimulus(K_JMEM, 0, 2, 1'b0, 6'h3f);
        apply_stimulus(K_PCTOREG, 0, 0, 1'b1, 6'h3f);
        apply_stimulus(K_SW, 1, 0, 1'b0, 6'h3f);
        apply_stimulus(K_ILL, 0, 0, 1'b0, 6'h3f);

        for (int i = 0; i < 40; i++)
            apply_stimulus(kind_t'($urandom_range(9)), int'($urandom_range(3)), int'($urandom_range(3)),
                           1'($urandom_range(1)), random_illegal_op());

        // Fetch that never gets an ack: four request cycles, then an error cycle with the request dropped
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            if (c < 4) begin
                check_output("timeout_req_held", {mem_req, mem_err}, 2'b10);
            end else begin
                check_output("timeout_err_pulse", {mem_req, mem_err, pc_write, ir_write}, 4'b0100);
            end
        end
        apply_stimulus(K_R, 0, 0, 1'b1, 6'h3f);

        // Reset asserted while a store waits in MEM
        @(negedge clk);
        opcode  = 6'b101011;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_output("store_in_mem", {mem_req, mem_we, iord}, 3'b111);
        rst_n = 1'b0;
        #1;
        check_output("reset_drops_req", {mem_req, mem_we, iord}, 3'b000);
        check_output("reset_clears_z", z_flag, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        zm    = 1'b0;
        #1;
        check_output("post_reset_rst_state", mem_req, 1'b0);
        apply_stimulus(K_BMEM, 0, 0, 1'b0, 6'h3f);
        apply_stimulus(K_LW, 0, 0, 1'b1, 6'h3f);

        @(negedge clk);
        #1;
        check_output("final_z_flag", z_flag, zm);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the extended MIPS datapath. It replaces the single-cycle decode with an FSM that steps each instruction through fetch, decode, execute, memory and writeback over a single shared instruction/data memory port. The memory port uses a variable-latency req/ack handshake. The block sits between the instruction register and the datapath muxes, register file, PC and memory interface.

## Interface
- `MEM_TIMEOUT`, default 0: if non-zero, the maximum number of cycles to wait for `mem_ack` before `mem_err` fires. 0 disables the timeout.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], valid from ID onward.
- `funct` in 6: IR[5:0].
- `alu_zero` in 1: ALU zero output.
- `mem_ack` in 1: memory has completed the request this cycle.
- `mem_req` out 1: memory request; held until ack.
- `mem_we` out 1: write request (qualified by `mem_req`).
- `iord` out 1: 0 selects PC as the address, 1 selects ALUOut.
- `ir_write` out 1: load IR from read data.
- `pc_write` out 1: unconditional PC load.
- `pc_src` out 2: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = memory data register.
- `reg_write` out 1.
- `reg_dst` out 1: 1 selects rd, 0 selects rt.
- `wb_sel` out 2: 0 = ALUOut, 1 = MDR, 2 = PC (link).
- `alu_src_a` out 1: 0 selects PC, 1 selects rs.
- `alu_src_b` out 2: 0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = shifted immediate.
- `alu_op` out 2: 0 = add, 1 = sub, 2 = funct-decoded.
- `z_flag` out 1: architectural zero flag, used by `jz`.
- `illegal` out 1: one-cycle pulse in ID when the opcode/funct pair is undecoded.
- `mem_err` out 1: one-cycle pulse when the memory timeout fires.

## Operation
- Decoded classes:
  - R = 000000; within R, PCTOREG funct = 010110 and JMEM funct = 101101.
  - LW = 100011, SW = 101011, BEQ = 000100, BMEM = 010100, JS = 010011, JZ = 011010.
- States: RST, IF, ID, EX, MEM, WB.
- RST: all outputs 0. Goes to IF on the first clock edge with `rst_n` high.
- IF:
  - Drives `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=add.
  - On `mem_ack`: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to ID.
  - Without ack: stay in IF with the outputs stable and no PC/IR write.
- ID:
  - Computes the branch target: `alu_src_a`=0, `alu_src_b`=3.
  - Illegal class: pulse `illegal`, go to IF.
  - JZ: if `z_flag`, `pc_write`=1 with `pc_src`=2. Then go to IF.
  - All other classes go to EX.
- EX:
  - R: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2 → WB.
  - LW, SW, BMEM: rs + immediate (`alu_src_b`=2, add) → MEM.
  - JMEM: rs + 0 (`alu_src_b`=0 with rt forced by software to r0) → MEM.
  - BEQ: subtract. If `alu_zero`, `pc_write`=1 with `pc_src`=1. Then go to IF.
  - JS: go to MEM with `iord`=1 addressing the jump target; the datapath routes PC to the write data.
  - PCTOREG: skips the ALU and goes directly to WB.
- MEM:
  - `mem_req`=1, `iord`=1; `mem_we`=1 for SW and JS.
  - Waits for ack, then:
    - LW → WB.
    - SW → IF.
    - JS → IF with `pc_write`=1, `pc_src`=2.
    - JMEM → IF with `pc_write`=1, `pc_src`=3.
    - BMEM → IF with `pc_write`=`z_flag`, `pc_src`=3.
- WB: `reg_write`=1.
  - R: `reg_dst`=1, `wb_sel`=0.
  - LW: `reg_dst`=0, `wb_sel`=1.
  - PCTOREG: `reg_dst`=1, `wb_sel`=2.
  - Then go to IF.
- `z_flag` register:
  - Updated only in WB of a non-PCTOREG R instruction, taking the value `alu_zero` had in EX (latched at the end of EX).
  - Resets to 0.
- Timeout:
  - When `MEM_TIMEOUT` = N > 0, a wait counter runs in IF/MEM. It clears on entry and on ack.
  - On reaching N: pulse `mem_err`, drop `mem_req`, go to IF without writing PC.

## Timing
- All control outputs are Moore/Mealy decode of the registered state plus `mem_ack`/`alu_zero`. There is no output register stage.
- CPI with zero-wait memory (ack in the first request cycle): R 4, LW 5, SW 4, BEQ 3, JZ 2, BMEM/JMEM/JS 4, PCTOREG 4. Each memory wait cycle adds 1.
- `mem_req` rises in the cycle the FSM enters IF/MEM and stays high until the ack cycle inclusive. It falls in the following cycle, or stays high if the next state also requests.
- `rst_n` low at any time forces state RST, clears `z_flag`, and drops `mem_req` combinationally. An in-flight memory transaction is abandoned. After reset the PC is the datapath's responsibility.
- Ack outside IF/MEM is ignored.

## Structure
- Package `mctrl_pkg`: opcode/funct localparams, state encoding, and the `pc_src`, `wb_sel`, `alu_src_b` and `alu_op` encodings.
- Sub-module `op_class_decode`: combinational opcode/funct → one-hot class vector plus `illegal`.

## Test plan
- Reset, zero-wait memory, R add with result 0:
  - IF/ID/EX/WB occupy 4 cycles.
  - `reg_write`=1 in WB only.
  - `z_flag` becomes 1 after WB.
- LW with `mem_ack` delayed 3 cycles in both IF and MEM:
  - 11 cycles total.
  - `mem_req` stays high continuously through each wait.
  - `ir_write` fires exactly once.
- BEQ taken vs not taken:
  - Taken: `pc_write`=1 with `pc_src`=1 in EX.
  - Not taken: no PC write after IF.
- JZ with `z_flag`=1 → PC load with `pc_src`=2 in ID. With `z_flag`=0 → return to IF after 2 cycles with no PC write.
- JS: MEM cycle shows `mem_we`=1, `iord`=1, then `pc_src`=2. JMEM: `pc_src`=3 on ack.
- Error cases:
  - Opcode 111111 → `illegal` pulse in ID.
  - `rst_n` asserted mid-MEM → `mem_req`=0 immediately, state RST.
  - `MEM_TIMEOUT`=4 with no ack → `mem_err` after 4 cycles.
